// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential execute unit: opcodes and FSM states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHRA = 4'd7,
    OP_SHL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_ROL  = 4'd10,
    OP_NEG  = 4'd11,
    OP_NOT  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic is_iterative(input op_e o);
    return (o == OP_MUL) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Shared iterative datapath: radix-2 Booth multiply and signed restoring divide
// over one 2*WIDTH+1 accumulator, with the iteration counter and result fixup.
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic                    div_sel,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    last,
  output logic        [WIDTH-1:0] res_hi,
  output logic        [WIDTH-1:0] res_lo,
  output logic                    div_zero
);

  localparam int AW = 2 * WIDTH + 1;

  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] oper;
  logic             mode_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Add/subtract in WIDTH+1 bits so the most-negative multiplicand cannot
  // overflow before the arithmetic shift; the extra bit becomes the new sign.
  function automatic logic [AW-1:0] booth_step(input logic [AW-1:0] acc_v,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] hi_x;
    logic [WIDTH:0] m_x;
    logic [WIDTH:0] sum;
    hi_x = {acc_v[AW-1], acc_v[AW-1:WIDTH+1]};
    m_x  = {m[WIDTH-1], m};
    case (acc_v[1:0])
      2'b01:   sum = hi_x + m_x;
      2'b10:   sum = hi_x - m_x;
      default: sum = hi_x;
    endcase
    return {sum, acc_v[WIDTH:1]};
  endfunction

  // Remainder lives in acc[2W:W], quotient bits shift in at acc[0].
  function automatic logic [AW-1:0] div_step(input logic [AW-1:0] acc_v,
                                             input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {acc_v[2*WIDTH-1:WIDTH], acc_v[WIDTH-1]};
    diff = sh - {1'b0, d};
    if (diff[WIDTH]) return {sh, acc_v[WIDTH-2:0], 1'b0};
    return {diff, acc_v[WIDTH-2:0], 1'b1};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(WIDTH);
    end else if (step && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (load) begin
      mode_div <= div_sel;
      neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r    <= a[WIDTH-1];
      dz       <= (b == '0);
      if (div_sel) begin
        oper <= mag(b);
        acc  <= {{(WIDTH + 1){1'b0}}, mag(a)};
      end else begin
        oper <= a;
        acc  <= {{WIDTH{1'b0}}, b, 1'b0};
      end
    end else if (step) begin
      acc <= mode_div ? div_step(acc, oper) : booth_step(acc, oper);
    end
  end

  // With a zero divisor every trial succeeds, so the remainder ends as |a|
  // and the sign fixup restores a; only the quotient needs overriding.
  always_comb begin
    q_mag  = acc[WIDTH-1:0];
    r_mag  = acc[2*WIDTH-1:WIDTH];
    res_hi = acc[AW-1:WIDTH+1];
    res_lo = acc[WIDTH:1];
    if (mode_div) begin
      res_lo = dz ? '1 : (neg_q ? -q_mag : q_mag);
      res_hi = neg_r ? -r_mag : r_mag;
    end
  end

  assign div_zero = mode_div & dz;

endmodule

// File: rtl/alu_seq_exec.sv
// Execute unit producing the Z register pair: single-cycle logic/add/shift ops
// plus iterative MUL/DIV with a busy/done handshake toward the control unit.
module alu_seq_exec
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int               CNT_W   = $clog2(WIDTH + 1);
  localparam int               LOG_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_e           state;
  state_e           state_nxt;
  op_e              op_q;
  logic             iter_op;
  logic             single_wr;
  logic             accept;
  logic             load_md;
  logic [WIDTH-1:0] single_res;
  logic             md_last;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic             md_dz;

  function automatic logic [WIDTH-1:0] single_op(input op_e o,
                                                 input logic signed [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] n);
    logic [2*WIDTH-1:0]      dbl;
    logic [LOG_W-1:0]        rot;
    logic signed [WIDTH-1:0] sra;
    logic                    big;
    big = (n >= WIDTH_V);
    rot = n[LOG_W-1:0];
    dbl = {a, a};
    sra = a >>> n;
    case (o)
      OP_AND:  return a & n;
      OP_OR:   return a | n;
      OP_ADD:  return a + n;
      OP_SUB:  return a - n;
      OP_NEG:  return -a;
      OP_NOT:  return ~a;
      OP_SHR:  return big ? '0 : (a >> n);
      OP_SHL:  return big ? '0 : (a << n);
      OP_SHRA: return big ? {WIDTH{a[WIDTH-1]}} : sra;
      OP_ROR: begin
        dbl = dbl >> rot;
        return dbl[WIDTH-1:0];
      end
      OP_ROL: begin
        dbl = dbl << rot;
        return dbl[2*WIDTH-1:WIDTH];
      end
      default: return '0;
    endcase
  endfunction

  assign op_q       = op_e'(op);
  assign iter_op    = is_iterative(op_q);
  assign single_wr  = (op <= 4'd12) && !iter_op;
  assign accept     = (state == ST_IDLE) && start;
  assign load_md    = accept && iter_op;
  assign single_res = single_op(op_q, y_in, bus_in);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && iter_op) state_nxt = ST_RUN;
      ST_RUN:  if (md_last) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  alu_seq_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk      (Clock),
    .rst      (Clear),
    .load     (load_md),
    .step     (state == ST_RUN),
    .div_sel  (op_q == OP_DIV),
    .a        (y_in),
    .b        (bus_in),
    .last     (md_last),
    .res_hi   (md_hi),
    .res_lo   (md_lo),
    .div_zero (md_dz)
  );

  // Undefined opcodes still acknowledge with done but leave Z untouched.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      z_hi     <= '0;
      z_lo     <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        div_zero <= 1'b0;
        if (!iter_op) begin
          done <= 1'b1;
          if (single_wr) begin
            z_hi <= '0;
            z_lo <= single_res;
          end
        end
      end else if (state == ST_FIX) begin
        done     <= 1'b1;
        z_hi     <= md_hi;
        z_lo     <= md_lo;
        div_zero <= md_dz;
      end
    end
  end

endmodule
